// File: rtl/dtw_pkg.sv
// Shared constants and FSM encoding for the DTW core sequencer.
package dtw_pkg;

  localparam int unsigned WIDTH_DEF    = 16;
  localparam int unsigned SQG_SIZE_DEF = 250;
  localparam int unsigned REF_AW_DEF   = 20;
  localparam logic [WIDTH_DEF-1:0] PAD_DEF = {WIDTH_DEF{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PRIME,
    S_STREAM,
    S_DRAIN,
    S_SETTLE,
    S_RESULT
  } state_e;

endpackage

// File: rtl/dtw_ref_prefetch.sv
// Two-entry reference RAM read skid buffer; supplies PAD once all words are issued and drained.
module dtw_ref_prefetch
  import dtw_pkg::*;
#(
  parameter int unsigned      WIDTH  = WIDTH_DEF,
  parameter int unsigned      REF_AW = REF_AW_DEF,
  parameter logic [WIDTH-1:0] PAD    = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [REF_AW-1:0] i_base,
  input  logic [31:0]       i_len,
  input  logic              i_en,
  input  logic              i_pop,
  input  logic [WIDTH-1:0]  i_rdata,
  output logic              o_rd_en,
  output logic [REF_AW-1:0] o_addr,
  output logic              o_avail,
  output logic [WIDTH-1:0]  o_word
);

  logic [REF_AW-1:0] r_base;
  logic [31:0]       r_len;
  logic [31:0]       r_issued;
  logic              r_inflight;
  logic [WIDTH-1:0]  r_buf [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_cnt;

  logic              w_more;
  logic              w_pad_mode;
  logic              w_pop;
  logic [2:0]        w_occ;

  assign w_more     = (r_issued < r_len);
  assign w_pad_mode = !w_more && !r_inflight && (r_cnt == 2'd0);
  assign w_pop      = i_pop && (r_cnt != 2'd0);
  // Occupancy after this cycle's pop, so a steady pop/issue stream never starves.
  assign w_occ      = 3'(r_cnt) + 3'(r_inflight) - 3'(w_pop);

  assign o_rd_en = i_en && w_more && (w_occ < 3'd2);
  assign o_addr  = r_base + REF_AW'(r_issued);
  assign o_avail = (r_cnt != 2'd0) || w_pad_mode;
  assign o_word  = (r_cnt != 2'd0) ? r_buf[r_rd_ptr] : PAD;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_cnt      <= 2'd0;
    end else if (i_load) begin
      r_base     <= i_base;
      r_len      <= i_len;
      r_issued   <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_inflight <= o_rd_en;
      if (o_rd_en) r_issued <= r_issued + 32'd1;
      if (r_inflight) begin
        r_buf[r_wr_ptr] <= i_rdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/dtw_core_ctrl.sv
// Run sequencer for one DTW datapath: clear, prime, stream samples/words, drain, settle, report.
// Optional DTW_CTRL_PERF_EN adds per-run cycle and stall counters on the result port.
module dtw_core_ctrl
  import dtw_pkg::*;
#(
  parameter int unsigned      WIDTH    = WIDTH_DEF,
  parameter int unsigned      SQG_SIZE = SQG_SIZE_DEF,
  parameter int unsigned      REF_AW   = REF_AW_DEF,
  parameter logic [WIDTH-1:0] PAD      = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [REF_AW-1:0] i_ref_base,
  input  logic [31:0]       i_ref_len,
  output logic              o_busy,
  input  logic              i_sqg_valid,
  input  logic [WIDTH-1:0]  i_sqg_data,
  output logic              o_sqg_ready,
  output logic              o_ref_rd_en,
  output logic [REF_AW-1:0] o_ref_addr,
  input  logic [WIDTH-1:0]  i_ref_rdata,
  output logic              o_dp_rst,
  output logic              o_dp_running,
  output logic [WIDTH-1:0]  o_dp_squiggle,
  output logic [WIDTH-1:0]  o_dp_rword,
  output logic [31:0]       o_dp_ref_len,
  input  logic [WIDTH-1:0]  i_dp_minval,
  input  logic [31:0]       i_dp_position,
  input  logic              i_dp_done,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [WIDTH-1:0]  o_res_minval,
  output logic [31:0]       o_res_position,
  output logic              o_res_err
`ifdef DTW_CTRL_PERF_EN
  ,
  output logic [31:0]       o_res_cycles,
  output logic [31:0]       o_res_stalls
`endif
);

  localparam int unsigned SW = $clog2(SQG_SIZE + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [SW-1:0]    r_samples;
  logic [31:0]      r_len;
  logic [WIDTH-1:0] r_res_minval;
  logic [31:0]      r_res_position;
  logic             r_res_err;

  logic             w_accept;
  logic             w_running;
  logic             w_sqg_take;
  logic             w_pop;
  logic             w_pf_en;
  logic             w_pf_avail;
  logic [WIDTH-1:0] w_pf_word;

  assign w_accept = (r_state == S_IDLE) && i_start;

  dtw_ref_prefetch #(
    .WIDTH  (WIDTH),
    .REF_AW (REF_AW),
    .PAD    (PAD)
  ) u_prefetch (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_base  (i_ref_base),
    .i_len   (i_ref_len),
    .i_en    (w_pf_en),
    .i_pop   (w_pop),
    .i_rdata (i_ref_rdata),
    .o_rd_en (o_ref_rd_en),
    .o_addr  (o_ref_addr),
    .o_avail (w_pf_avail),
    .o_word  (w_pf_word)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus the per-cycle advance/consume strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_running   = 1'b0;
    w_sqg_take  = 1'b0;
    w_pop       = 1'b0;
    w_pf_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = (i_ref_len == 32'd0) ? S_RESULT : S_CLEAR;
      end
      S_CLEAR: begin
        w_pf_en     = 1'b1;
        w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        w_pf_en     = 1'b1;
        w_running   = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_pf_en    = 1'b1;
        w_running  = i_sqg_valid && w_pf_avail;
        w_sqg_take = w_running;
        w_pop      = w_running;
        if (w_running && (r_samples == SW'(SQG_SIZE - 1))) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_pf_en   = 1'b1;
        w_running = w_pf_avail && !i_dp_done;
        w_pop     = w_running;
        if (i_dp_done) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        w_pf_en     = 1'b1;
        w_running   = 1'b1;
        w_pop       = w_pf_avail;
        w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        if (i_res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samples      <= '0;
      r_len          <= '0;
      r_res_minval   <= '0;
      r_res_position <= '0;
      r_res_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_len     <= i_ref_len;
        r_samples <= '0;
        if (i_ref_len == 32'd0) begin
          r_res_err      <= 1'b1;
          r_res_minval   <= {WIDTH{1'b1}};
          r_res_position <= '0;
        end else begin
          r_res_err <= 1'b0;
        end
      end
      if (w_sqg_take) r_samples <= r_samples + SW'(1);
      // Minimum register lags the last row by one, so sample it on the SETTLE edge.
      if (r_state == S_SETTLE) begin
        r_res_minval   <= i_dp_minval;
        r_res_position <= i_dp_position;
      end
      if ((r_state == S_RESULT) && i_res_ready) r_res_err <= 1'b0;
    end
  end

`ifdef DTW_CTRL_PERF_EN
  logic [31:0] r_cycles;
  logic [31:0] r_stalls;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles <= '0;
      r_stalls <= '0;
    end else if (w_accept) begin
      r_cycles <= '0;
      r_stalls <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_RESULT)) r_cycles <= r_cycles + 32'd1;
      if ((r_state == S_STREAM) && !w_running)          r_stalls <= r_stalls + 32'd1;
    end
  end

  assign o_res_cycles = r_cycles;
  assign o_res_stalls = r_stalls;
`endif

  assign o_busy         = (r_state != S_IDLE);
  assign o_sqg_ready    = w_sqg_take;
  assign o_dp_rst       = rst || (r_state == S_CLEAR);
  assign o_dp_running   = w_running;
  assign o_dp_squiggle  = i_sqg_data;
  assign o_dp_rword     = w_pf_word;
  assign o_dp_ref_len   = r_len;
  assign o_res_valid    = (r_state == S_RESULT);
  assign o_res_minval   = r_res_minval;
  assign o_res_position = r_res_position;
  assign o_res_err      = r_res_err;

endmodule

// File: tb/tb_dtw_core_ctrl.sv
// Directed bench for dtw_core_ctrl with a behavioural RAM, sample source and datapath stand-in.
module tb_dtw_core_ctrl;

  logic        clk;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [19:0] ref_base = '0;
  logic [31:0] ref_len = '0;
  logic        res_ready = 1'b0;

  logic        sqg_valid = 1'b0;
  logic [15:0] sqg_data = '0;
  logic [15:0] ref_rdata = '0;
  logic [15:0] dp_minval = '0;
  logic [31:0] dp_position = '0;
  logic        dp_done = 1'b0;

  logic        busy, sqg_ready, ref_rd_en, dp_rst, dp_running, res_valid, res_err;
  logic [19:0] ref_addr;
  logic [15:0] dp_squiggle, dp_rword, res_minval;
  logic [31:0] dp_ref_len, res_position;
`ifdef DTW_CTRL_PERF_EN
  logic [31:0] res_cycles, res_stalls;
`endif

  int checks = 0;
  int errors = 0;
  int stall_after = 0;
  int stall_len = 0;

  // Monitor/stand-in state
  logic        m_rd = 1'b0, m_run = 1'b0, m_take = 1'b0, m_dprst = 1'b0;
  logic [19:0] m_addr = '0;
  logic [15:0] m_sq = '0, m_rw = '0, acc = '0;
  int          run_cnt = 0, fed = 0, stall_cnt = 0;
  int          rd_cnt = 0, wcnt = 0, midstall = 0;
  logic [19:0] addr_log [16];
  logic [15:0] wlog [16];

  dtw_core_ctrl #(.WIDTH(16), .SQG_SIZE(4), .REF_AW(20), .PAD(16'hFFFF)) dut (
`ifdef DTW_CTRL_PERF_EN
    .o_res_cycles   (res_cycles),
    .o_res_stalls   (res_stalls),
`endif
    .clk            (clk),
    .rst            (rst),
    .i_start        (start),
    .i_ref_base     (ref_base),
    .i_ref_len      (ref_len),
    .o_busy         (busy),
    .i_sqg_valid    (sqg_valid),
    .i_sqg_data     (sqg_data),
    .o_sqg_ready    (sqg_ready),
    .o_ref_rd_en    (ref_rd_en),
    .o_ref_addr     (ref_addr),
    .i_ref_rdata    (ref_rdata),
    .o_dp_rst       (dp_rst),
    .o_dp_running   (dp_running),
    .o_dp_squiggle  (dp_squiggle),
    .o_dp_rword     (dp_rword),
    .o_dp_ref_len   (dp_ref_len),
    .i_dp_minval    (dp_minval),
    .i_dp_position  (dp_position),
    .i_dp_done      (dp_done),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_res_minval   (res_minval),
    .o_res_position (res_position),
    .o_res_err      (res_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1);
  end

  // Drive at negedge from last edge's events, sample 1 time unit before the next posedge.
  always begin
    @(negedge clk);
    if (m_rd) ref_rdata = m_addr[15:0] ^ 16'h5A00;
    if (m_dprst) begin
      run_cnt = 0; acc = '0; fed = 0; stall_cnt = 0;
    end else begin
      if (m_run) run_cnt++;
      if (m_take) begin
        acc = acc + (m_sq ^ m_rw);
        fed++;
        if (fed == stall_after) stall_cnt = stall_len;
      end
    end
    sqg_valid = (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
    sqg_data    = 16'h0010 + 16'(fed);
    dp_done     = (run_cnt >= 8);
    dp_minval   = acc;
    dp_position = 32'(run_cnt);
    #4;
    m_rd = ref_rd_en; m_addr = ref_addr; m_run = dp_running; m_take = sqg_ready;
    m_sq = dp_squiggle; m_rw = dp_rword; m_dprst = dp_rst;
    if (start && !busy) begin
      rd_cnt = 0; wcnt = 0; midstall = 0;
    end
    if (m_rd) begin
      if (rd_cnt < 16) addr_log[rd_cnt] = m_addr;
      rd_cnt++;
    end
    if (m_run) begin
      if (wcnt < 16) wlog[wcnt] = m_rw;
      wcnt++;
    end
    if (busy && !m_run && fed >= 1 && fed < 4) midstall++;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_start(input logic [19:0] b, input logic [31:0] l);
    ref_base = b;
    ref_len  = l;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_res();
    int k = 0;
    while (!res_valid && k < 200) begin
      step();
      k++;
    end
    chk("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic wait_fed(input int n);
    int k = 0;
    while (fed < n && k < 200) begin
      step();
      k++;
    end
    chk("wait_fed_timeout", 32'(fed >= n), 32'd1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_valid_after_accept", 32'(res_valid), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sqg_ready", 32'(sqg_ready), 32'd0);
    chk("rst_rd_en", 32'(ref_rd_en), 32'd0);
    chk("rst_running", 32'(dp_running), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_dp_rst", 32'(dp_rst), 32'd1);
    chk("rst_ref_addr", 32'(ref_addr), 32'd0);
    chk("rst_res_minval", 32'(res_minval), 32'd0);
    chk("rst_res_position", res_position, 32'd0);
    rst = 1'b0;
    step();
    chk("dp_rst_released", 32'(dp_rst), 32'd0);

    // Run 1: base 0x100, 8 words, no stalls
    do_start(20'h00100, 32'd8);
    chk("r1_busy", 32'(busy), 32'd1);
    chk("r1_dp_ref_len", dp_ref_len, 32'd8);
    wait_res();
    chk("r1_rd_cnt", 32'(rd_cnt), 32'd8);
    for (int i = 0; i < 8; i++) chk("r1_addr", 32'(addr_log[i]), 32'h100 + 32'(i));
    chk("r1_stream_stalls", 32'(midstall), 32'd0);
    chk("r1_run_cycles", 32'(wcnt), 32'd9);
    for (int i = 1; i < 9; i++) chk("r1_word", 32'(wlog[i]), 32'h5B00 + 32'(i - 1));
    chk("r1_minval", 32'(res_minval), 32'h6C40);
    chk("r1_position", res_position, 32'd8);
    chk("r1_err", 32'(res_err), 32'd0);
`ifdef DTW_CTRL_PERF_EN
    chk("r1_perf_stalls", res_stalls, 32'd0);
    chk("r1_perf_cycles", res_cycles, 32'd11);
`endif
    for (int i = 0; i < 5; i++) begin
      chk("r1_hold_valid", 32'(res_valid), 32'd1);
      chk("r1_hold_minval", 32'(res_minval), 32'h6C40);
      chk("r1_hold_position", res_position, 32'd8);
      step();
    end
    accept();

    // Run 2: sample source drops valid for 3 cycles after the 2nd sample
    stall_after = 2;
    stall_len   = 3;
    do_start(20'h00100, 32'd8);
    wait_res();
    chk("r2_stream_stalls", 32'(midstall), 32'd3);
    chk("r2_minval", 32'(res_minval), 32'h6C40);
    chk("r2_position", res_position, 32'd8);
    chk("r2_rd_cnt", 32'(rd_cnt), 32'd8);
`ifdef DTW_CTRL_PERF_EN
    chk("r2_perf_stalls", res_stalls, 32'd3);
    chk("r2_perf_cycles", res_cycles, 32'd14);
`endif
    accept();
    stall_after = 0;
    stall_len   = 0;

    // Run 3: ref_len == 0 is rejected straight to RESULT
    do_start(20'h00300, 32'd0);
    chk("r3_res_valid", 32'(res_valid), 32'd1);
    chk("r3_res_err", 32'(res_err), 32'd1);
    chk("r3_minval", 32'(res_minval), 32'hFFFF);
    chk("r3_position", res_position, 32'd0);
    accept();
    chk("r3_err_cleared", 32'(res_err), 32'd0);
    chk("r3_no_reads", 32'(rd_cnt), 32'd0);
    chk("r3_no_running", 32'(wcnt), 32'd0);

    // Run 4: address wrap at 2^20
    do_start(20'hFFFFE, 32'd4);
    wait_res();
    chk("r4_rd_cnt", 32'(rd_cnt), 32'd4);
    chk("r4_addr0", 32'(addr_log[0]), 32'hFFFFE);
    chk("r4_addr1", 32'(addr_log[1]), 32'hFFFFF);
    chk("r4_addr2", 32'(addr_log[2]), 32'h00000);
    chk("r4_addr3", 32'(addr_log[3]), 32'h00001);
    chk("r4_word_pad", 32'(wlog[5]), 32'hFFFF);
    chk("r4_minval", 32'(res_minval), 32'h0000);
    accept();

    // Run 5: reset mid-stream, then a clean run
    do_start(20'h00100, 32'd8);
    wait_fed(2);
    rst = 1'b1;
    step();
    chk("r5_busy_in_rst", 32'(busy), 32'd0);
    chk("r5_dp_rst_in_rst", 32'(dp_rst), 32'd1);
    chk("r5_valid_in_rst", 32'(res_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("r5_dp_rst_after", 32'(dp_rst), 32'd0);
    chk("r5_busy_after", 32'(busy), 32'd0);
    do_start(20'h00100, 32'd8);
    wait_res();
    chk("r5_minval", 32'(res_minval), 32'h6C40);
    chk("r5_position", res_position, 32'd8);
    chk("r5_rd_cnt", 32'(rd_cnt), 32'd8);
    accept();

    // Run 6: start pulses in DRAIN and RESULT are ignored
    do_start(20'h00100, 32'd8);
    wait_fed(4);
    ref_base = 20'h00200;
    ref_len  = 32'd5;
    start    = 1'b1;
    step();
    start    = 1'b0;
    chk("r6_busy_drain", 32'(busy), 32'd1);
    chk("r6_len_drain", dp_ref_len, 32'd8);
    wait_res();
    chk("r6_minval", 32'(res_minval), 32'h6C40);
    chk("r6_rd_cnt", 32'(rd_cnt), 32'd8);
    chk("r6_last_addr", 32'(addr_log[7]), 32'h107);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("r6_valid_result", 32'(res_valid), 32'd1);
    chk("r6_len_result", dp_ref_len, 32'd8);
    chk("r6_minval_result", 32'(res_minval), 32'h6C40);
    accept();
    step();
    chk("r6_idle_stays", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
